// File: rtl/dma_controller_if.sv
// -----------------------------------------------------------------------------
// dma_if -- signal bundle for dma_controller.
//
// Groups the CPU register-write port, the local synchronous RAM port and the
// DRAM request/acknowledge port.
//   master : the view used by dma_controller (drives RAM/DRAM requests, status)
//   slave  : the view used by whatever surrounds the controller (CPU, RAM, DRAM)
//
// CPU side   : en, addr[15:0], data_in[15:0], write_enable -> controller
//              dma_status                                  <- controller
// RAM side   : ram_addr[15:0], ram_data_out[15:0], ram_we  <- controller
//              ram_data_in[15:0] (one cycle after ram_addr) -> controller
// DRAM side  : dram_addr[23:0], dram_data_out[31:0],
//              dram_req_read, dram_req_write               <- controller
//              dram_data_in[31:0], dram_data_valid,
//              dram_write_complete                         -> controller
// -----------------------------------------------------------------------------
interface dma_if;
   // CPU register port
   logic        en;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        write_enable;
   logic        dma_status;

   // Local RAM port
   logic [15:0] ram_addr;
   logic [15:0] ram_data_out;
   logic        ram_we;
   logic [15:0] ram_data_in;

   // DRAM port
   logic [23:0] dram_addr;
   logic [31:0] dram_data_out;
   logic        dram_req_read;
   logic        dram_req_write;
   logic [31:0] dram_data_in;
   logic        dram_data_valid;
   logic        dram_write_complete;

   modport master (
      input  en, addr, data_in, write_enable,
      input  ram_data_in,
      input  dram_data_in, dram_data_valid, dram_write_complete,
      output dma_status,
      output ram_addr, ram_data_out, ram_we,
      output dram_addr, dram_data_out, dram_req_read, dram_req_write
   );

   modport slave (
      output en, addr, data_in, write_enable,
      output ram_data_in,
      output dram_data_in, dram_data_valid, dram_write_complete,
      input  dma_status,
      input  ram_addr, ram_data_out, ram_we,
      input  dram_addr, dram_data_out, dram_req_read, dram_req_write
   );
endinterface

// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller -- moves blocks of 16-bit words between a local synchronous
// RAM and a 32-bit-word DRAM.
//
// Ports
//   clk : sole clock, everything changes on its rising edge
//   rst : synchronous active-high reset, aborts any transfer
//   bus : dma_if.master (CPU register writes, local RAM port, DRAM port)
//
// The CPU programs COUNT (16-bit words), PERIPH (DRAM word address), LOCAL
// (RAM word address) and then writes CONTROL; bit 0 picks the direction
// (0: RAM->DRAM, 1: DRAM->RAM). Registers only accept writes while idle.
// Two consecutive RAM words form one DRAM word, low address in bits [15:0].
// An odd COUNT leaves a final half word: writes pad bits [31:16] with zero,
// reads store only the low half to RAM.
// -----------------------------------------------------------------------------
module dma_controller (
   input  logic clk,
   input  logic rst,
   dma_if.master bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAM_RD_LO = 3'd1,
      RAM_RD_HI = 3'd2,
      DRAM_WR   = 3'd3,
      DRAM_RD   = 3'd4,
      RAM_WR_LO = 3'd5,
      RAM_WR_HI = 3'd6
   } state_t;

   localparam logic [1:0] DMA_CONTROL_ADDR = 2'd0;
   localparam logic [1:0] DMA_LOCAL_ADDR   = 2'd1;
   localparam logic [1:0] DMA_PERIPH_ADDR  = 2'd2;
   localparam logic [1:0] DMA_COUNT_ADDR   = 2'd3;

   state_t      state_q, state_d;

   // Programmed registers
   logic [15:0] local_q, local_d;
   logic [15:0] periph_q, periph_d;
   logic [15:0] count_q, count_d;

   // Transfer bookkeeping: RAM words still to move, and the upper half of
   // the DRAM word just read, parked until the RAM_WR_HI cycle.
   logic [15:0] remain_q, remain_d;
   logic [15:0] rd_hi_q, rd_hi_d;

   // Registered outputs
   logic [15:0] ram_addr_q, ram_addr_d;
   logic [15:0] ram_data_out_q, ram_data_out_d;
   logic        ram_we_q, ram_we_d;
   logic [23:0] dram_addr_q, dram_addr_d;
   logic [31:0] dram_data_out_q, dram_data_out_d;
   logic        dram_req_read_q, dram_req_read_d;
   logic        dram_req_write_q, dram_req_write_d;

   logic        reg_wr;
   logic        last_pair;

   // Only addr[1:0] selects a register; the rest of the word address is
   // deliberately ignored.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^bus.addr[15:2];

   assign reg_wr    = bus.en && bus.write_enable && (state_q == IDLE);
   assign last_pair = (remain_q <= 16'd2);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         local_q          <= 16'h0000;
         periph_q         <= 16'h0000;
         count_q          <= 16'h0000;
         remain_q         <= 16'h0000;
         rd_hi_q          <= 16'h0000;
         ram_addr_q       <= 16'h0000;
         ram_data_out_q   <= 16'h0000;
         ram_we_q         <= 1'b0;
         dram_addr_q      <= 24'h000000;
         dram_data_out_q  <= 32'h00000000;
         dram_req_read_q  <= 1'b0;
         dram_req_write_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         local_q          <= local_d;
         periph_q         <= periph_d;
         count_q          <= count_d;
         remain_q         <= remain_d;
         rd_hi_q          <= rd_hi_d;
         ram_addr_q       <= ram_addr_d;
         ram_data_out_q   <= ram_data_out_d;
         ram_we_q         <= ram_we_d;
         dram_addr_q      <= dram_addr_d;
         dram_data_out_q  <= dram_data_out_d;
         dram_req_read_q  <= dram_req_read_d;
         dram_req_write_q <= dram_req_write_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      local_d          = local_q;
      periph_d         = periph_q;
      count_d          = count_q;
      remain_d         = remain_q;
      rd_hi_d          = rd_hi_q;
      ram_addr_d       = ram_addr_q;
      ram_data_out_d   = ram_data_out_q;
      ram_we_d         = 1'b0;
      dram_addr_d      = dram_addr_q;
      dram_data_out_d  = dram_data_out_q;
      dram_req_read_d  = dram_req_read_q;
      dram_req_write_d = dram_req_write_q;

      case (state_q)
         IDLE: begin
            if (reg_wr) begin
               case (bus.addr[1:0])
                  DMA_CONTROL_ADDR: begin
                     // COUNT=0 is accepted but starts nothing
                     if (count_q != 16'h0000) begin
                        remain_d    = count_q;
                        ram_addr_d  = local_q;
                        dram_addr_d = {8'h00, periph_q};
                        if (bus.data_in[0]) begin
                           state_d         = DRAM_RD;
                           dram_req_read_d = 1'b1;
                        end else begin
                           state_d = RAM_RD_LO;
                        end
                     end
                  end
                  DMA_LOCAL_ADDR:  local_d  = bus.data_in;
                  DMA_PERIPH_ADDR: periph_d = bus.data_in;
                  DMA_COUNT_ADDR:  count_d  = bus.data_in;
                  default: ;
               endcase
            end
         end

         // Low word address is on ram_addr; its data appears next cycle.
         RAM_RD_LO: begin
            ram_addr_d = ram_addr_q + 16'd1;
            state_d    = RAM_RD_HI;
         end

         // Low word data is on ram_data_in now; high address is presented.
         RAM_RD_HI: begin
            dram_data_out_d = {dram_data_out_q[31:16], bus.ram_data_in};
            state_d         = DRAM_WR;
         end

         // First DRAM_WR cycle completes the data word (the high RAM word
         // arrives now) and raises the request, so addr/data are already
         // stable for the whole time the request is visible.
         DRAM_WR: begin
            if (!dram_req_write_q) begin
               dram_data_out_d  = {(remain_q == 16'd1) ? 16'h0000 : bus.ram_data_in,
                                   dram_data_out_q[15:0]};
               dram_req_write_d = 1'b1;
            end else if (bus.dram_write_complete) begin
               dram_req_write_d = 1'b0;
               if (last_pair) begin
                  state_d = IDLE;
               end else begin
                  remain_d    = remain_q - 16'd2;
                  ram_addr_d  = ram_addr_q + 16'd1;
                  dram_addr_d = dram_addr_q + 24'd1;
                  state_d     = RAM_RD_LO;
               end
            end
         end

         DRAM_RD: begin
            if (dram_req_read_q && bus.dram_data_valid) begin
               dram_req_read_d = 1'b0;
               rd_hi_d         = bus.dram_data_in[31:16];
               ram_data_out_d  = bus.dram_data_in[15:0];
               ram_we_d        = 1'b1;
               state_d         = RAM_WR_LO;
            end
         end

         // Low half is being written; an odd final word ends here.
         RAM_WR_LO: begin
            if (remain_q == 16'd1) begin
               state_d = IDLE;
            end else begin
               ram_addr_d     = ram_addr_q + 16'd1;
               ram_data_out_d = rd_hi_q;
               ram_we_d       = 1'b1;
               state_d        = RAM_WR_HI;
            end
         end

         // Request stays low through RAM_WR_LO/HI, giving the required gap
         // before the next read request.
         RAM_WR_HI: begin
            if (last_pair) begin
               state_d = IDLE;
            end else begin
               remain_d        = remain_q - 16'd2;
               ram_addr_d      = ram_addr_q + 16'd1;
               dram_addr_d     = dram_addr_q + 24'd1;
               dram_req_read_d = 1'b1;
               state_d         = DRAM_RD;
            end
         end

         default: begin
            state_d          = IDLE;
            dram_req_read_d  = 1'b0;
            dram_req_write_d = 1'b0;
         end
      endcase
   end

   assign bus.dma_status     = (state_q != IDLE);
   assign bus.ram_addr       = ram_addr_q;
   assign bus.ram_data_out   = ram_data_out_q;
   assign bus.ram_we         = ram_we_q;
   assign bus.dram_addr      = dram_addr_q;
   assign bus.dram_data_out  = dram_data_out_q;
   assign bus.dram_req_read  = dram_req_read_q;
   assign bus.dram_req_write = dram_req_write_q;

endmodule

// File: tb/tb_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_dma_controller -- self-checking bench for dma_controller.
//
// Surroundings: a 64K x 16 synchronous RAM model, a DRAM responder with a
// programmable acknowledge delay (plus optional stray acks while idle) whose
// read data is a fixed function of the DRAM address, and a monitor that logs
// RAM writes and the RAM address sequence. Expected DRAM/RAM traffic is
// computed per transfer from the programmed COUNT/LOCAL/PERIPH values.
// -----------------------------------------------------------------------------
module tb_dma_controller;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dma_if bus ();

   dma_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------------------------------------------------------- RAM model
   logic [15:0] ram_mem [0:65535];
   bit          ram_const_mode = 1'b0;
   logic [15:0] ram_const      = 16'h0000;

   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data_out;
      bus.ram_data_in <= ram_const_mode ? ram_const : ram_mem[bus.ram_addr];
   end

   function automatic logic [15:0] ram_val(input logic [15:0] a);
      return ram_const_mode ? ram_const : ram_mem[a];
   endfunction

   // --------------------------------------------------------------- DRAM model
   bit          dram_const_mode = 1'b0;
   logic [31:0] dram_const      = 32'h0;

   function automatic logic [31:0] dram_word(input logic [23:0] a);
      return dram_const_mode ? dram_const : (({8'h00, a} * 32'h9E3779B1) ^ 32'h5A5AC3C3);
   endfunction

   typedef struct {
      logic [23:0] a;
      logic [31:0] d;
   } dtx_t;

   dtx_t        wr_log[$];
   logic [23:0] rd_log[$];
   int          ack_delay   = 0;
   bit          stray_en    = 1'b0;
   longint      last_ack_t  = 0;

   initial begin
      int   waited;
      bit   acked_prev;
      dtx_t t;
      waited     = 0;
      acked_prev = 1'b0;
      bus.dram_write_complete = 1'b0;
      bus.dram_data_valid     = 1'b0;
      bus.dram_data_in        = 32'h0;
      forever begin
         @(negedge clk);
         bus.dram_write_complete = 1'b0;
         bus.dram_data_valid     = 1'b0;
         if (rst) begin
            waited     = 0;
            acked_prev = 1'b0;
         end else begin
            // a request must drop the cycle after its acknowledge
            if (acked_prev)
               check("req_drop_after_ack", {bus.dram_req_write, bus.dram_req_read}, 2'b00);
            acked_prev = 1'b0;
            if (bus.dram_req_write || bus.dram_req_read) begin
               if (waited >= ack_delay) begin
                  waited     = 0;
                  acked_prev = 1'b1;
                  last_ack_t = $time;
                  if (bus.dram_req_write) begin
                     t.a = bus.dram_addr;
                     t.d = bus.dram_data_out;
                     wr_log.push_back(t);
                     bus.dram_write_complete = 1'b1;
                  end else begin
                     rd_log.push_back(bus.dram_addr);
                     bus.dram_data_in    = dram_word(bus.dram_addr);
                     bus.dram_data_valid = 1'b1;
                  end
               end else begin
                  waited++;
               end
            end else begin
               waited = 0;
               if (stray_en && $urandom_range(3) == 0) begin
                  bus.dram_data_in = $urandom;
                  if ($urandom_range(1) == 1) bus.dram_write_complete = 1'b1;
                  else                        bus.dram_data_valid     = 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------ monitor
   logic [15:0] ramw_a[$];
   logic [15:0] ramw_d[$];
   logic [15:0] trace[$];
   bit          mon_write_path = 1'b0;
   longint      last_we_t      = 0;

   initial begin
      logic        prev_rw, prev_rr;
      logic [55:0] prev_w;
      logic [23:0] prev_ra;
      prev_rw = 1'b0;
      prev_rr = 1'b0;
      prev_w  = '0;
      prev_ra = '0;
      forever begin
         @(negedge clk);
         if (!rst && bus.dma_status) begin
            check("req_exclusive", bus.dram_req_read & bus.dram_req_write, 1'b0);
            if (mon_write_path) check("ram_we_in_write_path", bus.ram_we, 1'b0);
            if (prev_rw && bus.dram_req_write)
               check("wr_req_stable", {bus.dram_addr, bus.dram_data_out}, prev_w);
            if (prev_rr && bus.dram_req_read)
               check("rd_req_stable", bus.dram_addr, prev_ra);
            if (trace.size() == 0 || trace[$] != bus.ram_addr) trace.push_back(bus.ram_addr);
         end
         if (!rst && bus.ram_we) begin
            ramw_a.push_back(bus.ram_addr);
            ramw_d.push_back(bus.ram_data_out);
            last_we_t = $time;
         end
         prev_rw = !rst && bus.dram_req_write;
         prev_rr = !rst && bus.dram_req_read;
         prev_w  = {bus.dram_addr, bus.dram_data_out};
         prev_ra = bus.dram_addr;
      end
   end

   // -------------------------------------------------------------- watchdog
   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ CPU tasks
   task automatic cpu_wr(input logic [1:0] r, input logic [15:0] d, input bit en_v);
      logic [13:0] upper;
      upper = 14'($urandom);
      @(negedge clk);
      bus.en           = en_v;
      bus.write_enable = 1'b1;
      bus.addr         = {upper, r};
      bus.data_in      = d;
      @(negedge clk);
      bus.en           = 1'b0;
      bus.write_enable = 1'b0;
      bus.addr         = 16'($urandom);
      bus.data_in      = 16'($urandom);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.dma_status === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_in_budget"}, bus.dma_status, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_status"},   bus.dma_status, 1'b0);
      check({tag, "_ram_we"},   bus.ram_we, 1'b0);
      check({tag, "_reqs"},     {bus.dram_req_read, bus.dram_req_write}, 2'b00);
      check({tag, "_ram_bus"},  {bus.ram_addr, bus.ram_data_out}, 32'h0);
      check({tag, "_dram_bus"}, {bus.dram_addr, bus.dram_data_out}, 56'h0);
   endtask

   // One complete transfer: compute expected traffic, program, start, wait,
   // compare. prog=0 reuses registers from earlier; poke=1 tries register
   // writes while busy, which must have no effect.
   task automatic run_xfer(input string tag, input bit rd, input logic [15:0] loc,
                           input logic [15:0] per, input logic [15:0] cnt,
                           input bit prog, input bit poke);
      dtx_t        exp_wr[$];
      logic [23:0] exp_rda[$];
      logic [15:0] exp_ra[$];
      logic [15:0] exp_rdat[$];
      logic [15:0] exp_tr[$];
      dtx_t        t;
      logic [31:0] w;
      logic [15:0] lo, hi;
      int          n, pairs, budget;
      longint      fall_t;
      n     = int'(cnt);
      pairs = (n + 1) / 2;

      for (int k = 0; k < pairs; k++) begin
         if (!rd) begin
            lo  = ram_val(loc + 16'(2 * k));
            hi  = (2 * k + 1 < n) ? ram_val(loc + 16'(2 * k + 1)) : 16'h0000;
            t.a = {8'h00, per} + 24'(k);
            t.d = {hi, lo};
            exp_wr.push_back(t);
         end else begin
            exp_rda.push_back({8'h00, per} + 24'(k));
         end
      end
      for (int i = 0; i < n; i++) begin
         exp_tr.push_back(loc + 16'(i));
         if (rd) begin
            w = dram_word({8'h00, per} + 24'(i / 2));
            exp_ra.push_back(loc + 16'(i));
            exp_rdat.push_back((i % 2 == 1) ? w[31:16] : w[15:0]);
         end
      end

      wr_log.delete(); rd_log.delete();
      ramw_a.delete(); ramw_d.delete(); trace.delete();
      mon_write_path = !rd;

      if (prog) begin
         cpu_wr(2'd3, cnt, 1'b1);
         cpu_wr(2'd2, per, 1'b1);
         cpu_wr(2'd1, loc, 1'b1);
         cpu_wr(2'd3, 16'($urandom), 1'b0);   // en=0: must be ignored
      end
      cpu_wr(2'd0, {15'($urandom), rd}, 1'b1);
      check({tag, "_status_after_start"}, bus.dma_status, (cnt != 16'h0000));

      if (poke) begin
         cpu_wr(2'd3, 16'd1, 1'b1);
         cpu_wr(2'd1, ~loc, 1'b1);
         cpu_wr(2'd2, ~per, 1'b1);
         cpu_wr(2'd0, {15'h0, ~rd}, 1'b1);
      end

      budget = n * (16 + 2 * ack_delay) + 40;
      wait_idle(tag, budget);
      fall_t = $time;
      if (n > 0) begin
         if (rd) check({tag, "_status_fall_timing"}, 64'(fall_t - last_we_t), 64'd10);
         else    check({tag, "_status_fall_timing"}, 64'(fall_t - last_ack_t), 64'd10);
      end

      check({tag, "_n_dram_wr"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
         check($sformatf("%s_dram_wr%0d", tag, i),
               {wr_log[i].a, wr_log[i].d}, {exp_wr[i].a, exp_wr[i].d});

      check({tag, "_n_dram_rd"}, rd_log.size(), exp_rda.size());
      for (int i = 0; i < exp_rda.size() && i < rd_log.size(); i++)
         check($sformatf("%s_dram_rd%0d", tag, i), rd_log[i], exp_rda[i]);

      check({tag, "_n_ram_wr"}, ramw_a.size(), exp_ra.size());
      for (int i = 0; i < exp_ra.size() && i < ramw_a.size(); i++)
         check($sformatf("%s_ram_wr%0d", tag, i),
               {ramw_a[i], ramw_d[i]}, {exp_ra[i], exp_rdat[i]});

      // an odd write transfer may touch one spare RAM address; skip it there
      if (rd || (n % 2 == 0)) begin
         check({tag, "_n_ram_addr"}, trace.size(), exp_tr.size());
         for (int i = 0; i < exp_tr.size() && i < trace.size(); i++)
            check($sformatf("%s_ram_addr%0d", tag, i), trace[i], exp_tr[i]);
      end

      check({tag, "_idle_reqs"}, {bus.dram_req_read, bus.dram_req_write, bus.ram_we}, 3'b000);
      $display("xfer %s dir=%0d local=%h periph=%h count=%0d delay=%0d dram_wr=%0d dram_rd=%0d ram_wr=%0d",
               tag, rd, loc, per, cnt, ack_delay, wr_log.size(), rd_log.size(), ramw_a.size());
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int          n;
      logic [15:0] loc, per, cnt;
      bit          rd;

      bus.en           = 1'b0;
      bus.write_enable = 1'b0;
      bus.addr         = 16'h0;
      bus.data_in      = 16'h0;
      for (int i = 0; i < 65536; i++) ram_mem[i] = 16'($urandom);

      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_held");
      rst = 1'b0;
      @(negedge clk);
      check_outputs_zero("after_reset");

      // RAM->DRAM, constant RAM data
      ram_const_mode = 1'b1;
      ram_const      = 16'habcd;
      run_xfer("wr16_const", 1'b0, 16'hbeef, 16'hf00d, 16'd16, 1'b1, 1'b0);
      ram_const_mode = 1'b0;

      // DRAM->RAM, constant DRAM data
      dram_const_mode = 1'b1;
      dram_const      = 32'h12345678;
      run_xfer("rd16_const", 1'b1, 16'hfe00, 16'h00c0, 16'd16, 1'b1, 1'b0);
      dram_const_mode = 1'b0;

      // delayed acknowledges
      ack_delay = 3;
      run_xfer("wr_delay3", 1'b0, 16'h1000, 16'h2000, 16'd10, 1'b1, 1'b0);
      ack_delay = 8;
      run_xfer("rd_delay8", 1'b1, 16'h3000, 16'h4000, 16'd10, 1'b1, 1'b0);
      run_xfer("wr_delay8", 1'b0, 16'h5000, 16'h6000, 16'd7, 1'b1, 1'b0);
      ack_delay = 0;

      // odd counts, single word, zero count, wrap of RAM/DRAM addresses
      run_xfer("wr3_odd",  1'b0, 16'h0100, 16'h0200, 16'd3, 1'b1, 1'b0);
      run_xfer("rd5_odd",  1'b1, 16'h0400, 16'h0500, 16'd5, 1'b1, 1'b0);
      run_xfer("wr1",      1'b0, 16'h0600, 16'h0700, 16'd1, 1'b1, 1'b0);
      run_xfer("count0",   1'b0, 16'h0800, 16'h0900, 16'd0, 1'b1, 1'b0);
      run_xfer("rd_wrap",  1'b1, 16'hfffc, 16'hfffe, 16'd8, 1'b1, 1'b0);

      // register writes while busy are ignored; a second CONTROL-only start
      // must still use the original COUNT/LOCAL/PERIPH
      ack_delay = 3;
      run_xfer("busy_poke", 1'b0, 16'h7000, 16'h7100, 16'd6, 1'b1, 1'b1);
      run_xfer("restart",   1'b0, 16'h7000, 16'h7100, 16'd6, 1'b0, 1'b0);

      // reset while a DRAM write is pending
      ack_delay = 30;
      mon_write_path = 1'b1;
      cpu_wr(2'd3, 16'd8, 1'b1);
      cpu_wr(2'd2, 16'h1234, 1'b1);
      cpu_wr(2'd1, 16'h4321, 1'b1);
      cpu_wr(2'd0, 16'h0000, 1'b1);
      n = 0;
      while (bus.dram_req_write !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_req_seen", bus.dram_req_write, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("abort_next_cycle");
      rst = 1'b0;
      ack_delay = 0;
      wr_log.delete(); rd_log.delete(); ramw_a.delete();
      repeat (10) @(negedge clk);
      check_outputs_zero("abort_quiet");
      check("abort_no_dram", wr_log.size() + rd_log.size(), 0);
      check("abort_no_ram_wr", ramw_a.size(), 0);
      $display("xfer abort_in_dram_wr quiet_cycles=10 dram=%0d ram_wr=%0d",
               wr_log.size() + rd_log.size(), ramw_a.size());

      // randomized transfers with random delays and stray acknowledges
      stray_en = 1'b1;
      for (int r = 0; r < 10; r++) begin
         rd        = 1'($urandom);
         loc       = 16'($urandom);
         per       = 16'($urandom);
         cnt       = 16'($urandom_range(20, 1));
         ack_delay = $urandom_range(8);
         run_xfer($sformatf("rand%0d", r), rd, loc, per, cnt, 1'b1, 1'b0);
      end
      stray_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 The module SHALL have no parameters; all widths below are fixed.
REQ-002 The module SHALL use one clock and a synchronous, active-high reset, named as in the port list below.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 en  in  1  chip select; register writes take effect only when en=1.
REQ-006 addr  in  16  CPU word address (byte address >>1); register selected by addr[1:0].
REQ-007 data_in  in  16  CPU write data.
REQ-008 write_enable  in  1  CPU register write strobe, sampled per clk.
REQ-009 dma_status  out  1  1 while a transfer is in progress.
REQ-010 ram_addr  out  16  local RAM word address.
REQ-011 ram_data_out  out  16  local RAM write data.
REQ-012 ram_we  out  1  local RAM write enable, one cycle per word.
REQ-013 ram_data_in  in  16  local RAM read data, valid 1 cycle after ram_addr (synchronous RAM).
REQ-014 dram_addr  out  24  DRAM address, 32-bit-word granularity.
REQ-015 dram_data_out  out  32  DRAM write data.
REQ-016 dram_req_read  out  1  DRAM read request (level).
REQ-017 dram_req_write  out  1  DRAM write request (level).
REQ-018 dram_data_in  in  32  DRAM read data, valid when dram_data_valid=1.
REQ-019 dram_data_valid  in  1  one-cycle read-completion pulse.
REQ-020 dram_write_complete  in  1  one-cycle write-completion pulse.

Function
REQ-021 Register map (addr[1:0]): 0 CONTROL (DMA_CONTROL_ADDR), 1 LOCAL (DMA_LOCAL_ADDR), 2 PERIPH (DMA_PERIPH_ADDR), 3 COUNT (DMA_COUNT_ADDR); all 16-bit, write-only.
REQ-022 A register SHALL be written on a clk edge with en=1, write_enable=1 and dma_status=0; writes while busy SHALL be ignored.
REQ-023 A CONTROL write SHALL start a transfer; data_in[0]=0 selects RAM->DRAM (write), 1 selects DRAM->RAM (read); other bits ignored.
REQ-024 dma_status SHALL rise the cycle after the CONTROL write and fall the cycle after the last word completes; COUNT=0 SHALL leave dma_status at 0.
REQ-025 COUNT is in 16-bit RAM words; RAM words pair into DRAM words: word at LOCAL+2k -> dram bits [15:0], LOCAL+2k+1 -> bits [31:16].
REQ-026 DRAM word k SHALL use dram_addr = {8'h00, PERIPH} + k; ram_addr SHALL increment by 1 per RAM word (16-bit wrap).
REQ-027 Odd COUNT: final write SHALL carry 16'h0000 in bits [31:16]; final read SHALL write only the low half to RAM.
REQ-028 States: IDLE, RAM_RD_LO, RAM_RD_HI, DRAM_WR, DRAM_RD, RAM_WR_LO, RAM_WR_HI.
REQ-029 Write path: IDLE->RAM_RD_LO->RAM_RD_HI->DRAM_WR; DRAM_WR holds dram_req_write=1 with stable addr/data until dram_write_complete, then next pair or IDLE.
REQ-030 Read path: IDLE->DRAM_RD; hold dram_req_read=1 until dram_data_valid, latch dram_data_in, then RAM_WR_LO->RAM_WR_HI (ram_we=1 each cycle), then next DRAM_RD or IDLE.
REQ-031 Requests SHALL deassert the cycle after their ack, stay low at least one cycle before re-asserting, and never both be high.
REQ-032 Acks arriving while no request is pending SHALL be ignored.
REQ-033 ram_we SHALL be 0 throughout write-path transfers.

Reset
REQ-034 rst SHALL clear all registers and force IDLE; dma_status, ram_we, dram_req_read and dram_req_write SHALL be 0; ram_addr, ram_data_out, dram_addr and dram_data_out SHALL be 0.
REQ-035 rst mid-transfer SHALL abort immediately with no further RAM or DRAM activity.

Verification
REQ-036 COUNT=16, PERIPH=f00d, LOCAL=beef, CONTROL=0, ram_data_in=abcd -> 8 DRAM writes, addr 00f00d..00f014, data abcdabcd, ram_addr beef..befe, then dma_status falls.
REQ-037 COUNT=16, PERIPH=00c0, LOCAL=fe00, CONTROL=1, dram_data_in=12345678 -> 8 reads at 0000c0..0000c7, RAM writes 5678@fe00, 1234@fe01, ... through fe0f.
REQ-038 Ack delayed 3 and 8 cycles -> request held steady until ack, no duplicate transfers.
REQ-039 COUNT=3 write -> 2 DRAM writes, second with data[31:16]=0000.
REQ-040 rst during DRAM_WR -> all outputs 0 the next cycle; CONTROL write while busy -> ignored.
